// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for the five-stage core.
//
// Produces operand forwarding selects, per-stage stall enables and flush
// strobes for the F/D, D/E, E/M and M/W pipeline registers. A two-state FSM
// (RUN/WAIT) freezes the whole pipeline while the data memory has not yet
// acknowledged a request, with a forced release after TIMEOUT_CYCLES wait
// cycles. Saturating stall/flush event counters and a sticky timeout flag
// support bring-up and performance analysis.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   Rs1D, Rs2D                      Decode source registers
//   Rs1E, Rs2E, RdE, ResultSrcE     Execute sources, destination, result select
//   PCSrcE                          taken branch/jump resolved in Execute
//   RdM, RegWriteM                  Memory destination and write enable
//   MemReqM, MemReadyM              data memory request / acknowledge
//   RdW, RegWriteW                  Writeback destination and write enable
//   ForwardAE, ForwardBE            operand selects (00 RF, 01 WB, 10 MEM)
//   StallF/D/E/M                    hold PC and pipeline registers
//   FlushD/E/W                      clear F/D, D/E, M/W control fields
//   MemTimeout                      sticky memory-wait timeout flag
//   StallCount, FlushCount          saturating event counters
module hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [1:0]           ResultSrcE,
    input  logic                 PCSrcE,
    input  logic [4:0]           RdM,
    input  logic                 RegWriteM,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic                 MemTimeout,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic [CNT_WIDTH-1:0] FlushCount
);

    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCW-1:0] TMO = WCW'(TIMEOUT_CYCLES);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_cnt_nxt;
    logic           mem_stall;
    logic           lw_stall;
    logic           timeout_hit;

    // State register, wait counter, sticky timeout flag and event counters.
    // Counters observe the gated stall/flush outputs, so they count exactly
    // the cycles the pipeline saw a stall or a Decode flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state      <= next_state;
            wait_cnt   <= wait_cnt_nxt;
            MemTimeout <= MemTimeout | timeout_hit;
            if (StallF && (StallCount != '1)) begin
                StallCount <= StallCount + 1'b1;
            end
            if (FlushD && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end

    // Memory-wait FSM. The first unacknowledged cycle is stalled from RUN,
    // so entering WAIT with wait_cnt = 1 makes an N-wait access stall for
    // exactly N cycles. On timeout the stall drops in the same cycle.
    always_comb begin
        next_state   = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    mem_stall    = 1'b1;
                    next_state   = WAIT;
                    wait_cnt_nxt = WCW'(1);
                end
            end
            WAIT: begin
                if (MemReadyM) begin
                    next_state   = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == TMO) begin
                    next_state   = RUN;
                    wait_cnt_nxt = '0;
                    timeout_hit  = 1'b1;
                end else begin
                    mem_stall    = 1'b1;
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                next_state   = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // Forwarding and stall/flush outputs. Reset forces a bubble everywhere;
    // a memory stall freezes all stages and hides load-use and redirects,
    // which re-appear on the release cycle because Execute was held.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
                ForwardAE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
                ForwardAE = 2'b01;
            end
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
                ForwardBE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
                ForwardBE = 2'b01;
            end
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushE = lw_stall | PCSrcE;
                FlushD = PCSrcE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed bench for hazard_ctrl with TIMEOUT_CYCLES = 4. A second instance
// with 2-bit counters shares all inputs so counter saturation is visible.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW, MemTimeout;
    logic [31:0] StallCount, FlushCount;

    logic [1:0] satForwardAE, satForwardBE;
    logic       satStallF, satStallD, satStallE, satStallM;
    logic       satFlushD, satFlushE, satFlushW, satMemTimeout;
    logic [1:0] satStallCount, satFlushCount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(2)) dutSat (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .ForwardAE(satForwardAE), .ForwardBE(satForwardBE),
        .StallF(satStallF), .StallD(satStallD), .StallE(satStallE), .StallM(satStallM),
        .FlushD(satFlushD), .FlushE(satFlushE), .FlushW(satFlushW),
        .MemTimeout(satMemTimeout), .StallCount(satStallCount), .FlushCount(satFlushCount)
    );

    // Advance to the next cycle; inputs are then driven 1 time unit after
    // the rising edge and sampled another unit later, far from either edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        rst_n = 1'b0;
        // Hazard-inducing inputs during reset must be gated off
        RdM = 5; RegWriteM = 1; Rs1E = 5; MemReqM = 1;
        applyStimulus();
        settle();
        checkOutput("rst_flushD", FlushD, 1);
        checkOutput("rst_flushE", FlushE, 1);
        checkOutput("rst_flushW", FlushW, 1);
        checkOutput("rst_stallF", StallF, 0);
        checkOutput("rst_stallM", StallM, 0);
        checkOutput("rst_fwdA", ForwardAE, 0);
        checkOutput("rst_stallCnt", StallCount, 0);
        checkOutput("rst_flushCnt", FlushCount, 0);
        checkOutput("rst_timeout", MemTimeout, 0);

        // Leave reset
        applyStimulus();
        rst_n = 1'b1;
        clearInputs();
        settle();
        checkOutput("idle_flushD", FlushD, 0);
        checkOutput("idle_flushW", FlushW, 0);
        checkOutput("idle_stallF", StallF, 0);

        // Forwarding priority and x0 suppression
        RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
        settle();
        checkOutput("fwd_mem_A", ForwardAE, 2'b10);
        checkOutput("fwd_mem_B", ForwardBE, 2'b10);
        RegWriteM = 0;
        settle();
        checkOutput("fwd_wb_A", ForwardAE, 2'b01);
        RdM = 0; RdW = 0; RegWriteM = 1; Rs1E = 0; Rs2E = 0;
        settle();
        checkOutput("fwd_x0_A", ForwardAE, 2'b00);
        checkOutput("fwd_x0_B", ForwardBE, 2'b00);
        RdM = 6; RdW = 5; Rs1E = 5; Rs2E = 6;
        settle();
        checkOutput("fwd_split_A", ForwardAE, 2'b01);
        checkOutput("fwd_split_B", ForwardBE, 2'b10);

        // Load-use stall lasts one cycle
        applyStimulus();
        clearInputs();
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        settle();
        checkOutput("lu_stallF", StallF, 1);
        checkOutput("lu_stallD", StallD, 1);
        checkOutput("lu_flushE", FlushE, 1);
        checkOutput("lu_flushD", FlushD, 0);
        checkOutput("lu_stallE", StallE, 0);
        applyStimulus();
        clearInputs();
        settle();
        checkOutput("lu_after_stallF", StallF, 0);
        checkOutput("lu_stallCnt", StallCount, 1);
        checkOutput("lu_flushCnt", FlushCount, 0);

        // A load writing x0 never causes a load-use stall
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        settle();
        checkOutput("lu_x0_stallF", StallF, 0);

        // Branch redirect
        applyStimulus();
        clearInputs();
        PCSrcE = 1;
        settle();
        checkOutput("br_flushD", FlushD, 1);
        checkOutput("br_flushE", FlushE, 1);
        checkOutput("br_stallF", StallF, 0);
        applyStimulus();
        clearInputs();
        settle();
        checkOutput("br_flushCnt", FlushCount, 1);
        checkOutput("br_stallCnt", StallCount, 1);

        // Branch together with load-use
        PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        settle();
        checkOutput("brlu_flushD", FlushD, 1);
        checkOutput("brlu_flushE", FlushE, 1);
        checkOutput("brlu_stallF", StallF, 1);
        checkOutput("brlu_stallD", StallD, 1);

        // Zero-wait memory access
        applyStimulus();
        clearInputs();
        MemReqM = 1; MemReadyM = 1;
        settle();
        checkOutput("zw_stallF", StallF, 0);
        checkOutput("zw_flushW", FlushW, 0);
        checkOutput("zw_stallCnt", StallCount, 2);
        checkOutput("zw_flushCnt", FlushCount, 2);

        // Three wait cycles with a branch held in Execute
        applyStimulus();
        clearInputs();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) applyStimulus();
            settle();
            checkOutput($sformatf("mw_stallF_%0d", i), StallF, 1);
            checkOutput($sformatf("mw_stallE_%0d", i), StallE, 1);
            checkOutput($sformatf("mw_stallM_%0d", i), StallM, 1);
            checkOutput($sformatf("mw_flushW_%0d", i), FlushW, 1);
            checkOutput($sformatf("mw_flushD_%0d", i), FlushD, 0);
        end
        applyStimulus();
        MemReadyM = 1;
        settle();
        checkOutput("mw_rel_stallF", StallF, 0);
        checkOutput("mw_rel_flushW", FlushW, 0);
        checkOutput("mw_rel_flushD", FlushD, 1);
        applyStimulus();
        clearInputs();
        settle();
        checkOutput("mw_run_stallF", StallF, 0);
        checkOutput("mw_stallCnt", StallCount, 5);
        checkOutput("mw_flushCnt", FlushCount, 3);
        checkOutput("mw_sat_flushCnt", satFlushCount, 2'b11);

        // Timeout: four stalled cycles, release on the fifth
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) applyStimulus();
            settle();
            checkOutput($sformatf("to_stallF_%0d", i), StallF, 1);
            checkOutput($sformatf("to_flag_%0d", i), MemTimeout, 0);
        end
        applyStimulus();
        settle();
        checkOutput("to_rel_stallF", StallF, 0);
        checkOutput("to_rel_stallM", StallM, 0);
        checkOutput("to_rel_flushW", FlushW, 0);
        applyStimulus();
        settle();
        checkOutput("to_flag_set", MemTimeout, 1);
        checkOutput("to_rewait_stallF", StallF, 1);
        checkOutput("to_stallCnt", StallCount, 9);
        checkOutput("to_sat_stallCnt", satStallCount, 2'b11);
        applyStimulus();
        settle();
        checkOutput("to_flag_sticky", MemTimeout, 1);
        checkOutput("to_wait_stallF", StallF, 1);

        // Reset during WAIT
        rst_n = 1'b0;
        settle();
        checkOutput("rw_flushD", FlushD, 1);
        checkOutput("rw_flushW", FlushW, 1);
        checkOutput("rw_stallF", StallF, 0);
        applyStimulus();
        settle();
        checkOutput("rw_stallCnt", StallCount, 0);
        checkOutput("rw_flushCnt", FlushCount, 0);
        checkOutput("rw_flag", MemTimeout, 0);
        checkOutput("rw_flushE", FlushE, 1);
        applyStimulus();
        rst_n = 1'b1;
        clearInputs();
        settle();
        checkOutput("rw_run_stallF", StallF, 0);
        checkOutput("rw_run_flushW", FlushW, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
